lsu_bus_ctrl: RTL

- Parametrised load/store unit between the core's memory stage and the data bus.
- Accepts one load/store request per transaction, drives a valid/ready bus with byte-lane enables, and tolerates slave wait states.
- Sign/zero-extends load data and returns a one-cycle response pulse; reports faults for illegal, misaligned or timed-out accesses.
- Generalised over DATA_W (32 or 64), ADDR_W and bus timeout.

---
 rtl/lsu_bus_ctrl_if.sv | 39 +++
 rtl/lsu_bus_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_ctrl_if.sv
// Request, response and data-bus signals of the load/store unit.
// master = the unit, slave = core plus memory side.
interface lsu_bus_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_fault;
  logic              bus_valid;
  logic              bus_ready;
  logic              bus_write;
  logic [ADDR_W-1:0] bus_addr;
  logic [NB-1:0]     bus_be;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  bus_ready, bus_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
    output bus_valid, bus_write, bus_addr, bus_be, bus_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output bus_ready, bus_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
    input  bus_valid, bus_write, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit: one request -> bus beat(s) -> extended response.
// LSU_MISALIGN_SPLIT_EN: serve misaligned accesses, splitting across words.
module lsu_bus_ctrl #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic           clk,
  input  logic           reset,
  lsu_bus_ctrl_if.master lsu
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam int MW = 2 * DATA_W;
`else
  localparam int MW = DATA_W;
`endif
  localparam int MB = MW / 8;

  typedef enum logic [2:0] {
    IDLE, BUS, RESP, FAULT
`ifdef LSU_MISALIGN_SPLIT_EN
    , BUS2
`endif
  } state_t;

  state_t            state, state_n;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cap_lo;
  logic [CW-1:0]     cnt;
  logic [3:0]        req_sz;
  logic [3:0]        sz_q;
  logic              ill;
  logic              bad;
  logic              tmo;
  logic [OW-1:0]     off;
  logic [NB-1:0]     keep;
  logic [MB-1:0]     be2;
  logic [MW-1:0]     wd2;
  logic [MW-1:0]     merged;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ld;
  logic              sbit;
  logic [ADDR_W-1:0] base;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [DATA_W-1:0] cap_hi;
  logic              cross;
`endif

  // Legality check on the incoming request.
  always_comb begin
    req_sz = 4'd1 << lsu.req_funct3[1:0];
    ill    = (req_sz > 4'(NB))
           | (lsu.req_funct3 == 3'b111)
           | (lsu.req_we & lsu.req_funct3[2])
           | ((lsu.req_funct3 == 3'b110) && (DATA_W == 32));
`ifdef LSU_MISALIGN_SPLIT_EN
    bad = ill;
`else
    bad = ill | (|(lsu.req_addr[2:0] & (req_sz[2:0] - 3'd1)));
`endif
  end

  // Lane masks, shifted write data and load extension.
  always_comb begin
    sz_q = 4'd1 << f3_q[1:0];
    off  = addr_q[OW-1:0];
    base = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
    for (int i = 0; i < NB; i++) keep[i] = (i < int'(sz_q));
    be2 = MB'(keep) << off;
    wd2 = MW'(wdata_q) << {off, 3'b000};
`ifdef LSU_MISALIGN_SPLIT_EN
    merged = {cap_hi, cap_lo};
    cross  = (int'(off) + int'(sz_q)) > NB;
`else
    merged = cap_lo;
`endif
    shifted = DATA_W'(merged >> {off, 3'b000});
    unique case (f3_q[1:0])
      2'd0:    sbit = shifted[7];
      2'd1:    sbit = shifted[15];
      2'd2:    sbit = shifted[31];
      default: sbit = shifted[DATA_W-1];
    endcase
    sbit = sbit & ~f3_q[2];
    for (int i = 0; i < NB; i++)
      ld[8*i +: 8] = keep[i] ? shifted[8*i +: 8] : {8{sbit}};
    tmo = ~lsu.bus_ready
        & (cnt == CW'(TIMEOUT_CYCLES - 1));
  end

  // Next state and all outputs, decoded from the current state.
  always_comb begin
    state_n       = state;
    lsu.req_ready = 1'b0;
    lsu.rsp_valid = 1'b0;
    lsu.rsp_fault = 1'b0;
    lsu.rsp_rdata = '0;
    lsu.bus_valid = 1'b0;
    lsu.bus_write = 1'b0;
    lsu.bus_addr  = '0;
    lsu.bus_be    = '0;
    lsu.bus_wdata = '0;
    unique case (state)
      IDLE: begin
        lsu.req_ready = 1'b1;
        if (lsu.req_valid) state_n = bad ? FAULT : BUS;
      end
      BUS: begin
        lsu.bus_valid = 1'b1;
        lsu.bus_write = we_q;
        lsu.bus_addr  = base;
        lsu.bus_be    = be2[NB-1:0];
        lsu.bus_wdata = wd2[DATA_W-1:0];
`ifdef LSU_MISALIGN_SPLIT_EN
        if (lsu.bus_ready) state_n = cross ? BUS2 : RESP;
`else
        if (lsu.bus_ready) state_n = RESP;
`endif
        else if (tmo) state_n = FAULT;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      BUS2: begin
        lsu.bus_valid = 1'b1;
        lsu.bus_write = we_q;
        lsu.bus_addr  = base + ADDR_W'(NB);
        lsu.bus_be    = be2[MB-1:NB];
        lsu.bus_wdata = wd2[MW-1:DATA_W];
        if (lsu.bus_ready) state_n = RESP;
        else if (tmo) state_n = FAULT;
      end
`endif
      RESP: begin
        lsu.rsp_valid = 1'b1;
        lsu.rsp_rdata = we_q ? '0 : ld;
        state_n       = IDLE;
      end
      FAULT: begin
        lsu.rsp_valid = 1'b1;
        lsu.rsp_fault = 1'b1;
        state_n       = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Request latch, per-beat wait counter and read-data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      cap_lo  <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      cap_hi  <= '0;
`endif
    end else begin
      if (state == IDLE && lsu.req_valid) begin
        we_q    <= lsu.req_we;
        f3_q    <= lsu.req_funct3;
        addr_q  <= lsu.req_addr;
        wdata_q <= lsu.req_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
        cap_hi  <= '0;
`endif
      end
      if (lsu.bus_valid && state_n == state) cnt <= cnt + CW'(1);
      else                                   cnt <= '0;
      if (state == BUS && lsu.bus_ready) cap_lo <= lsu.bus_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
      if (state == BUS2 && lsu.bus_ready) cap_hi <= lsu.bus_rdata;
`endif
    end
  end
endmodule
